// File: rtl/imsic_msi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : imsic_msi_arbiter
//  Purpose  : Round-robin arbiter that funnels MSI writes from NrReqs
//             requesters into a single registered IMSIC write port.
//             Optional request filter: IMSIC_MSI_ARB_FILTER_EN
//  Revision : 1.0 - initial release
// ============================================================================
module imsic_msi_arbiter #(
    parameter int NrReqs      = 4,
    parameter int NrIntpFiles = 3,
    parameter int NrSourcesW  = 5,
    localparam int FileW      = (NrIntpFiles > 1) ? $clog2(NrIntpFiles) : 1,
    localparam int SrcW       = (NrReqs > 1) ? $clog2(NrReqs) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NrReqs-1:0]            req_valid_i,
    output logic [NrReqs-1:0]            req_ready_o,
    input  logic [NrReqs*FileW-1:0]      req_file_i,
    input  logic [NrReqs*NrSourcesW-1:0] req_id_i,
    output logic                         msi_valid_o,
    input  logic                         msi_ready_i,
    output logic [FileW-1:0]             msi_file_o,
    output logic [NrSourcesW-1:0]        msi_id_o,
    output logic [SrcW-1:0]              msi_src_o,
    output logic [15:0]                  drop_cnt_o
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [SrcW-1:0] c_last_req = SrcW'(NrReqs - 1);

    state_t                  r_state;
    logic [SrcW-1:0]         r_rr_ptr;
    logic [FileW-1:0]        r_file;
    logic [NrSourcesW-1:0]   r_id;
    logic [SrcW-1:0]         r_src;

    logic                    w_gnt_found;
    logic [SrcW-1:0]         w_gnt_idx;
    logic [FileW-1:0]        w_sel_file;
    logic [NrSourcesW-1:0]   w_sel_id;
    int                      w_scan_idx;
    logic                    w_free;
    logic                    w_accept;
    logic                    w_drop;
    logic                    w_load;
    logic [SrcW-1:0]         w_next_ptr;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_sel_file  = '0;
        w_sel_id    = '0;
        w_scan_idx  = 0;
        for (int i = 0; i < NrReqs; i++) begin
            w_scan_idx = (int'(r_rr_ptr) + i) % NrReqs;
            if (!w_gnt_found && req_valid_i[w_scan_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = SrcW'(w_scan_idx);
                w_sel_file  = req_file_i[w_scan_idx*FileW +: FileW];
                w_sel_id    = req_id_i[w_scan_idx*NrSourcesW +: NrSourcesW];
            end
        end
    end

    // The output slot is usable if empty or being drained this very cycle.
    assign w_free     = (r_state == ST_EMPTY) || msi_ready_i;
    assign w_accept   = w_gnt_found && w_free && !rst_i;
    assign w_next_ptr = (w_gnt_idx == c_last_req) ? '0 : w_gnt_idx + 1'b1;

`ifdef IMSIC_MSI_ARB_FILTER_EN
    logic        w_sel_invalid;
    logic [15:0] r_drop_cnt;

    assign w_sel_invalid = (w_sel_id == '0) || (int'(w_sel_file) >= NrIntpFiles);
    assign w_drop        = w_accept && w_sel_invalid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt_o = r_drop_cnt;
`else
    assign w_drop     = 1'b0;
    assign drop_cnt_o = 16'd0;
`endif

    assign w_load = w_accept && !w_drop;

    always_comb begin
        req_ready_o = '0;
        if (w_accept) begin
            req_ready_o[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_EMPTY;
            r_rr_ptr <= '0;
            r_file   <= '0;
            r_id     <= '0;
            r_src    <= '0;
        end else begin
            if (w_accept) begin
                r_rr_ptr <= w_next_ptr;
            end
            if (w_load) begin
                r_state <= ST_FULL;
                r_file  <= w_sel_file;
                r_id    <= w_sel_id;
                r_src   <= w_gnt_idx;
            end else if ((r_state == ST_FULL) && msi_ready_i) begin
                r_state <= ST_EMPTY;
            end
        end
    end

    assign msi_valid_o = (r_state == ST_FULL);
    assign msi_file_o  = r_file;
    assign msi_id_o    = r_id;
    assign msi_src_o   = r_src;

endmodule
`default_nettype wire
